// File: rtl/tb4004_pkg.sv
// tb4004_pkg
//   Shared opcode constants and state type for the TB4004 core.
//   OPR_*     : instruction upper nibble values
//   OPA_F_*   : accumulator group (OPR = F) lower nibble values
//   OPA_E_*   : I/O and RAM group (OPR = E) lower nibble values
//   accState_e: acc_unit sequencer states
package tb4004_pkg;

  localparam logic [3:0] OPR_NOP = 4'h0;
  localparam logic [3:0] OPR_JCN = 4'h1;
  localparam logic [3:0] OPR_FIM = 4'h2;
  localparam logic [3:0] OPR_FIN = 4'h3;
  localparam logic [3:0] OPR_JUN = 4'h4;
  localparam logic [3:0] OPR_JMS = 4'h5;
  localparam logic [3:0] OPR_INC = 4'h6;
  localparam logic [3:0] OPR_ISZ = 4'h7;
  localparam logic [3:0] OPR_ADD = 4'h8;
  localparam logic [3:0] OPR_SUB = 4'h9;
  localparam logic [3:0] OPR_LD  = 4'hA;
  localparam logic [3:0] OPR_XCH = 4'hB;
  localparam logic [3:0] OPR_BBL = 4'hC;
  localparam logic [3:0] OPR_LDM = 4'hD;
  localparam logic [3:0] OPR_E   = 4'hE;
  localparam logic [3:0] OPR_F   = 4'hF;

  localparam logic [3:0] OPA_F_CLB = 4'h0;
  localparam logic [3:0] OPA_F_CLC = 4'h1;
  localparam logic [3:0] OPA_F_IAC = 4'h2;
  localparam logic [3:0] OPA_F_CMC = 4'h3;
  localparam logic [3:0] OPA_F_CMA = 4'h4;
  localparam logic [3:0] OPA_F_RAL = 4'h5;
  localparam logic [3:0] OPA_F_RAR = 4'h6;
  localparam logic [3:0] OPA_F_TCC = 4'h7;
  localparam logic [3:0] OPA_F_DAC = 4'h8;
  localparam logic [3:0] OPA_F_TCS = 4'h9;
  localparam logic [3:0] OPA_F_STC = 4'hA;
  localparam logic [3:0] OPA_F_DAA = 4'hB;
  localparam logic [3:0] OPA_F_KBP = 4'hC;
  localparam logic [3:0] OPA_F_DCL = 4'hD;

  localparam logic [3:0] OPA_E_WRM = 4'h0;
  localparam logic [3:0] OPA_E_WMP = 4'h1;
  localparam logic [3:0] OPA_E_WRR = 4'h2;
  localparam logic [3:0] OPA_E_WPM = 4'h3;
  localparam logic [3:0] OPA_E_WR0 = 4'h4;
  localparam logic [3:0] OPA_E_WR1 = 4'h5;
  localparam logic [3:0] OPA_E_WR2 = 4'h6;
  localparam logic [3:0] OPA_E_WR3 = 4'h7;
  localparam logic [3:0] OPA_E_SBM = 4'h8;
  localparam logic [3:0] OPA_E_RDM = 4'h9;
  localparam logic [3:0] OPA_E_RDR = 4'hA;
  localparam logic [3:0] OPA_E_ADM = 4'hB;
  localparam logic [3:0] OPA_E_RD0 = 4'hC;
  localparam logic [3:0] OPA_E_RD1 = 4'hD;
  localparam logic [3:0] OPA_E_RD2 = 4'hE;
  localparam logic [3:0] OPA_E_RD3 = 4'hF;

  typedef enum logic {
    ACC_IDLE,
    ACC_DAA
  } accState_e;

  // DAA is the only multi-cycle instruction the accumulator unit executes.
  function automatic logic isDaa(input logic [3:0] opr, input logic [3:0] opa);
    return (opr == OPR_F) && (opa == OPA_F_DAA);
  endfunction

endpackage

// File: rtl/acc_unit_if.sv
// acc_unit_if
//   Command handshake between the decoder (master) and acc_unit (slave).
//   cmd_valid : command present
//   cmd_ready : unit idle, command taken when valid & ready at the clock edge
//   opr / opa : instruction upper / lower nibble
interface acc_unit_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] opr;
  logic [3:0] opa;

  modport master (output cmd_valid, output opr, output opa, input cmd_ready);
  modport slave  (input cmd_valid, input opr, input opa, output cmd_ready);

endinterface

// File: rtl/acc_alu_core.sv
// acc_alu_core
//   Combinational next accumulator / carry for every single-cycle instruction.
//   i_opr, i_opa  : instruction nibbles
//   i_acc, i_carry: current accumulator and carry
//   i_reg         : index register Rr
//   i_mem         : RAM / status / port read data
//   o_nextAcc     : accumulator value to commit
//   o_nextCarry   : carry value to commit
//   o_regWe       : instruction writes old accumulator back to Rr (XCH)
module acc_alu_core
  import tb4004_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [3:0]       i_opr,
  input  logic [3:0]       i_opa,
  input  logic [WIDTH-1:0] i_acc,
  input  logic             i_carry,
  input  logic [WIDTH-1:0] i_reg,
  input  logic [WIDTH-1:0] i_mem,
  output logic [WIDTH-1:0] o_nextAcc,
  output logic             o_nextCarry,
  output logic             o_regWe
);

  logic             w_notCarry;
  logic [WIDTH-1:0] w_kbp;
  logic [WIDTH-1:0] w_kbpPos;
  int               w_kbpOnes;

  // Kept as its own 1-bit net so the borrow term is zero-extended, not inverted after widening.
  assign w_notCarry = ~i_carry;

  // KBP: position+1 of a lone set bit, zero for none, all-ones for an invalid multi-key press.
  always_comb begin
    w_kbpOnes = 0;
    w_kbpPos  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_acc[i]) begin
        w_kbpOnes = w_kbpOnes + 1;
        w_kbpPos  = WIDTH'(i + 1);
      end
    end
    if (w_kbpOnes == 0)      w_kbp = '0;
    else if (w_kbpOnes == 1) w_kbp = w_kbpPos;
    else                     w_kbp = '1;
  end

  // Instruction decode; anything unlisted leaves acc and carry as they are.
  always_comb begin
    o_nextAcc   = i_acc;
    o_nextCarry = i_carry;
    o_regWe     = 1'b0;
    case (i_opr)
      OPR_ADD: {o_nextCarry, o_nextAcc} = {1'b0, i_acc} + {1'b0, i_reg} + (WIDTH+1)'(i_carry);
      OPR_SUB: {o_nextCarry, o_nextAcc} = {1'b0, i_acc} + {1'b0, ~i_reg} + (WIDTH+1)'(w_notCarry);
      OPR_LD:  o_nextAcc = i_reg;
      OPR_XCH: begin
        o_nextAcc = i_reg;
        o_regWe   = 1'b1;
      end
      OPR_BBL, OPR_LDM: o_nextAcc = WIDTH'(i_opa);
      OPR_F: begin
        case (i_opa)
          OPA_F_CLB: begin
            o_nextAcc   = '0;
            o_nextCarry = 1'b0;
          end
          OPA_F_CLC: o_nextCarry = 1'b0;
          OPA_F_IAC: {o_nextCarry, o_nextAcc} = {1'b0, i_acc} + (WIDTH+1)'(1);
          OPA_F_CMC: o_nextCarry = w_notCarry;
          OPA_F_CMA: o_nextAcc = ~i_acc;
          OPA_F_RAL: {o_nextCarry, o_nextAcc} = {i_acc, i_carry};
          OPA_F_RAR: {o_nextAcc, o_nextCarry} = {i_carry, i_acc};
          OPA_F_TCC: begin
            o_nextAcc   = WIDTH'(i_carry);
            o_nextCarry = 1'b0;
          end
          OPA_F_DAC: begin
            o_nextAcc   = i_acc - WIDTH'(1);
            o_nextCarry = (i_acc != '0);
          end
          OPA_F_TCS: begin
            o_nextAcc   = i_carry ? WIDTH'(10) : WIDTH'(9);
            o_nextCarry = 1'b0;
          end
          OPA_F_STC: o_nextCarry = 1'b1;
          OPA_F_KBP: o_nextAcc = w_kbp;
          default: ;
        endcase
      end
      OPR_E: begin
        case (i_opa)
          OPA_E_RDM, OPA_E_RDR, OPA_E_RD0, OPA_E_RD1, OPA_E_RD2, OPA_E_RD3:
            o_nextAcc = i_mem;
          OPA_E_ADM: {o_nextCarry, o_nextAcc} = {1'b0, i_acc} + {1'b0, i_mem} + (WIDTH+1)'(i_carry);
          OPA_E_SBM: {o_nextCarry, o_nextAcc} = {1'b0, i_acc} + {1'b0, ~i_mem} + (WIDTH+1)'(w_notCarry);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_unit.sv
// acc_unit
//   Accumulator / carry execution unit for the TB4004 core, WIDTH = 4*N bits.
//   clk, reset_n : clock, asynchronous active-low reset
//   cmd          : command handshake (valid/ready, opr/opa)
//   reg_rdata    : index register Rr
//   mem_rdata    : RAM / status / port read data
//   acc, carry   : architectural accumulator and carry
//   acc_zero     : acc == 0
//   reg_we       : one-cycle pulse writing reg_wdata to Rr
//   reg_wdata    : old accumulator for XCH
//   done         : one-cycle pulse once a command has committed
module acc_unit
  import tb4004_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  acc_unit_if.slave        cmd,
  input  logic [WIDTH-1:0] reg_rdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             acc_zero,
  output logic             reg_we,
  output logic [WIDTH-1:0] reg_wdata,
  output logic             done
);

  localparam int N     = WIDTH / 4;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  accState_e        r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_regWe;
  logic [WIDTH-1:0] r_regWdata;
  logic             r_done;
  logic [CNT_W-1:0] r_digit;

  logic             w_accept;
  logic             w_isDaa;
  logic [WIDTH-1:0] w_aluAcc;
  logic             w_aluCarry;
  logic             w_aluRegWe;
  logic [CNT_W-1:0] w_daaIdx;
  logic [3:0]       w_digit;
  logic [WIDTH:0]   w_daaAdd;
  logic [WIDTH:0]   w_daaSum;
  logic             w_daaFix;
  logic [WIDTH-1:0] w_daaAcc;
  logic             w_daaCarry;
  logic             w_lastStep;

  assign cmd.cmd_ready = (r_state == ACC_IDLE);
  assign w_accept      = cmd.cmd_valid && (r_state == ACC_IDLE);
  assign w_isDaa       = isDaa(cmd.opr, cmd.opa);

  acc_alu_core #(
    .WIDTH(WIDTH)
  ) u_alu (
    .i_opr      (cmd.opr),
    .i_opa      (cmd.opa),
    .i_acc      (r_acc),
    .i_carry    (r_carry),
    .i_reg      (reg_rdata),
    .i_mem      (mem_rdata),
    .o_nextAcc  (w_aluAcc),
    .o_nextCarry(w_aluCarry),
    .o_regWe    (w_aluRegWe)
  );

  // Digit 0 is handled while still IDLE so a one-digit unit can finish DAA on the accept edge.
  assign w_daaIdx   = (r_state == ACC_DAA) ? r_digit : '0;
  assign w_lastStep = (w_daaIdx == CNT_W'(N - 1));

  // One DAA step: add 6 into the selected digit; the incoming carry only matters for digit 0.
  always_comb begin
    w_digit  = '0;
    w_daaAdd = '0;
    for (int d = 0; d < N; d++) begin
      if (CNT_W'(d) == w_daaIdx) begin
        w_digit  = r_acc[4*d +: 4];
        w_daaAdd = (WIDTH+1)'(6) << (4 * d);
      end
    end
    w_daaFix = (w_digit > 4'd9) || ((w_daaIdx == '0) && r_carry);
    w_daaSum = {1'b0, r_acc} + (w_daaFix ? w_daaAdd : '0);
  end

  // DAA can only set carry, never clear it.
  assign w_daaAcc   = w_daaSum[WIDTH-1:0];
  assign w_daaCarry = r_carry | w_daaSum[WIDTH];

  // Architectural state, handshake sequencer and registered done / Rr write pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ACC_IDLE;
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_regWe    <= 1'b0;
      r_regWdata <= '0;
      r_done     <= 1'b0;
      r_digit    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_regWe <= 1'b0;
      case (r_state)
        ACC_IDLE: begin
          if (w_accept) begin
            if (w_isDaa) begin
              if (N == 1) begin
                r_acc   <= w_daaAcc;
                r_carry <= w_daaCarry;
                r_done  <= 1'b1;
              end else begin
                r_state <= ACC_DAA;
                r_digit <= '0;
              end
            end else begin
              r_acc   <= w_aluAcc;
              r_carry <= w_aluCarry;
              r_done  <= 1'b1;
              if (w_aluRegWe) begin
                r_regWe    <= 1'b1;
                r_regWdata <= r_acc;
              end
            end
          end
        end
        ACC_DAA: begin
          r_acc   <= w_daaAcc;
          r_carry <= w_daaCarry;
          if (w_lastStep) begin
            r_state <= ACC_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_digit <= r_digit + CNT_W'(1);
          end
        end
        default: r_state <= ACC_IDLE;
      endcase
    end
  end

  assign acc       = r_acc;
  assign carry     = r_carry;
  assign acc_zero  = (r_acc == '0);
  assign reg_we    = r_regWe;
  assign reg_wdata = r_regWdata;
  assign done      = r_done;

endmodule
